// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_pkg : state encoding and default word format for mult_arbiter   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mult_pkg;

  localparam int c_default_n = 32;
  localparam int c_default_q = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } mult_state_e;

endpackage
`default_nettype wire

// File: rtl/mult_fix_point.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_fix_point : signed Q-format multiplier, sign-magnitude datapath |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module mult_fix_point
  import mult_pkg::*;
#(
  parameter int Q = c_default_q,
  parameter int N = c_default_n
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_result
);

  logic [N-1:0]   w_neg_a;
  logic [N-1:0]   w_neg_b;
  logic [N-2:0]   w_mag_a;
  logic [N-2:0]   w_mag_b;
  logic [2*N-3:0] w_prod;
  logic [N-2:0]   w_mag_r;
  logic           w_sign;
  logic [N-1:0]   w_sm;
  logic           w_unused;

  assign w_neg_a = -i_a;
  assign w_neg_b = -i_b;
  assign w_mag_a = i_a[N-1] ? w_neg_a[N-2:0] : i_a[N-2:0];
  assign w_mag_b = i_b[N-1] ? w_neg_b[N-2:0] : i_b[N-2:0];

  assign w_prod  = {{(N-1){1'b0}}, w_mag_a} * {{(N-1){1'b0}}, w_mag_b};
  assign w_mag_r = w_prod[N-2+Q:Q];
  assign w_sign  = i_a[N-1] ^ i_b[N-1];

  // A negative sign on a zero magnitude would read as 0x80..0; fold it to +0.
  assign w_sm     = (w_mag_r == '0) ? '0 : {w_sign, w_mag_r};
  assign o_result = w_sm[N-1] ? -{1'b0, w_sm[N-2:0]} : w_sm;

  assign w_unused = ^{w_neg_a[N-1], w_neg_b[N-1], w_prod[2*N-3:N-1+Q], w_prod[Q-1:0]};

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_arbiter : round-robin arbiter in front of one fixed-point       |
// |                multiplier; MULT_ARBITER_PRIO0_EN gives req 0 priority|
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N    = c_default_n,
  parameter int Q    = c_default_q,
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*N-1:0]       req_a,
  input  logic [NREQ*N-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N-1:0]            rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  mult_state_e     r_state;
  mult_state_e     w_state_next;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   r_id;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_rsp_data;
  logic [IW-1:0]   r_rsp_id;
  logic [IW-1:0]   w_grant_id;
  logic            w_grant_valid;
  logic            w_accept;
  logic [NREQ-1:0] w_cand;
  logic [IW:0]     w_sum;
  logic [NREQ-1:0] w_req_ready;
  logic [N-1:0]    w_product;
  logic [N-1:0]    w_a_arr [NREQ];
  logic [N-1:0]    w_b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[gi*N +: N];
      assign w_b_arr[gi] = req_b[gi*N +: N];
    end
  endgenerate

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_sum         = '0;
`ifdef MULT_ARBITER_PRIO0_EN
    w_cand = req_valid & ~NREQ'(1);
`else
    w_cand = req_valid;
`endif
    // Walk from farthest to nearest so the first requester after last_grant wins.
    for (int k = NREQ; k >= 1; k--) begin
      w_sum = {1'b0, r_last_grant} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      if (w_cand[w_sum[IW-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_sum[IW-1:0];
      end
    end
`ifdef MULT_ARBITER_PRIO0_EN
    if (req_valid[0]) begin
      w_grant_valid = 1'b1;
      w_grant_id    = '0;
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid && !rst) begin
          w_req_ready[w_grant_id] = 1'b1;
          w_accept                = 1'b1;
          w_state_next            = MUL;
        end
      end
      MUL:  w_state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= IW'(NREQ-1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a          <= w_a_arr[w_grant_id];
        r_b          <= w_b_arr[w_grant_id];
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == MUL) begin
        r_rsp_data <= w_product;
        r_rsp_id   <= r_id;
      end
    end
  end

  mult_fix_point #(
    .Q (Q),
    .N (N)
  ) u_mult (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_product)
  );

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// tb_mult_arbiter: directed vectors, multi-cycle corner sequences and a
// randomized run scored against a transaction-level model.
module tb_mult_arbiter;

  localparam int N    = 32;
  localparam int Q    = 12;
  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  mult_arbiter #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Fixed-point product from the value semantics: |a|*|b| scaled by 2^-Q,
  // 31-bit magnitude wrap, sign reapplied, negative zero folded to zero.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint va, vb, ma, mb, q;
    va = longint'(signed'(a));
    vb = longint'(signed'(b));
    ma = (va < 0 ? -va : va) & 64'h7FFF_FFFF;
    mb = (vb < 0 ? -vb : vb) & 64'h7FFF_FFFF;
    q  = ((ma * mb) >> Q) & 64'h7FFF_FFFF;
    if (q == 0) return 32'h0;
    if (a[31] ^ b[31]) return 32'(-q);
    return 32'(q);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int i;
`ifdef MULT_ARBITER_PRIO0_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int ready_index(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    case ($urandom_range(0, 2))
      0:       r = $urandom;
      1:       r = 32'($urandom_range(0, 32'h8000));
      default: r = -32'($urandom_range(0, 32'h8000));
    endcase
    return r;
  endfunction

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        id = ready_index(req_ready);
        chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        break;
      end
    end
  endtask

  task automatic run_single(input int idx, input int id, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    logic [NREQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
    set_op(id, a, b);
    req_valid = oh;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk($sformatf("v%0d_mul_valid", idx), 64'(rsp_valid), 64'd0);
    chk($sformatf("v%0d_mul_busy", idx), 64'(busy), 64'd1);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'd1);
    chk($sformatf("v%0d_rsp_data", idx), 64'(rsp_data), 64'(exp));
    chk($sformatf("v%0d_rsp_id", idx), 64'(rsp_id), 64'(id));
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d_idle_valid", idx), 64'(rsp_valid), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];
  int   fair_exp [5];
  int   pr_exp [4];

  initial begin
    int              g;
    int              m_stage;
    int              m_last;
    int              m_id;
    int              e_g;
    logic [31:0]     m_data;
    logic [NREQ-1:0] e_ready;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{2, 32'h0000_2000, 32'h0000_3000, 32'h0000_6000};
    vecs[1] = '{1, 32'hFFFF_E800, 32'h0000_2000, 32'hFFFF_D000};
    vecs[2] = '{0, 32'h0000_1000, 32'hFFFF_F000, 32'hFFFF_F000};
    vecs[3] = '{3, 32'hFFFF_F000, 32'hFFFF_F000, 32'h0000_1000};
    vecs[4] = '{2, 32'h0000_0000, 32'hFFFF_E800, 32'h0000_0000};
    vecs[5] = '{1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{0, 32'h0000_0800, 32'h0000_0800, 32'h0000_0400};
    vecs[7] = '{3, 32'h1234_5000, 32'h0001_0000, 32'h2345_0000};
    vecs[8] = '{1, 32'h8000_0000, 32'h0000_1000, 32'h0000_0000};
`ifdef MULT_ARBITER_PRIO0_EN
    fair_exp = '{0, 0, 0, 0, 0};
    pr_exp   = '{0, 0, 0, 0};
`else
    fair_exp = '{0, 1, 2, 3, 0};
    pr_exp   = '{0, 1, 0, 1};
`endif

    // Reset state, with every requester asking while rst is held.
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;

    for (int i = 0; i < 9; i++) run_single(i, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Fairness with all requesters held valid.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      chk($sformatf("fair_grant%0d", i), 64'(g), 64'(fair_exp[i]));
    end

    // Backpressure: response must hold while rsp_ready stays low.
    do_reset();
    set_op(3, 32'h0000_3000, 32'hFFFF_F800);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("bp_grant", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("bp_mul_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_data%0d", i), 64'(rsp_data), 64'hFFFF_E800);
      chk($sformatf("bp_id%0d", i), 64'(rsp_id), 64'd3);
      chk($sformatf("bp_ready%0d", i), 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk("bp_exit_busy", 64'(busy), 64'd0);
    chk("bp_exit_valid", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'b0001);

    // Reset pulsed while the multiplier stage is occupied.
    do_reset();
    rsp_ready = 1'b1;
    set_op(1, 32'h0000_2000, 32'h0000_2000);
    set_op(0, 32'h0000_1000, 32'h0000_1000);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rm_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("rm_in_mul", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_valid", 64'(rsp_valid), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_ready_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rm_next_grant", 64'(req_ready), 64'b0001);
    chk("rm_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rm_rsp_id", 64'(rsp_id), 64'd0);
    chk("rm_rsp_data", 64'(rsp_data), 64'h0000_1000);

    // Requesters 0 and 1 contending.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      chk($sformatf("prio_grant%0d", i), 64'(g), 64'(pr_exp[i]));
    end

    // Randomized traffic against the transaction model.
    do_reset();
    m_stage = 0;
    m_last  = NREQ - 1;
    m_id    = 0;
    m_data  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      e_g     = pick(req_valid, m_last);
      e_ready = '0;
      if (m_stage == 0 && e_g >= 0) e_ready[e_g] = 1'b1;
      chk("rnd_ready", 64'(req_ready), 64'(e_ready));
      chk("rnd_valid", 64'(rsp_valid), 64'(m_stage == 2));
      chk("rnd_busy", 64'(busy), 64'(m_stage != 0));
      if (m_stage == 2) begin
        chk("rnd_data", 64'(rsp_data), 64'(m_data));
        chk("rnd_id", 64'(rsp_id), 64'(m_id));
      end
      case (m_stage)
        0: begin
          if (e_g >= 0) begin
            m_data  = ref_mul(req_a[e_g*N +: N], req_b[e_g*N +: N]);
            m_id    = e_g;
            m_last  = e_g;
            m_stage = 1;
          end
        end
        1: m_stage = 2;
        default: if (rsp_ready) m_stage = 0;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
